onehot_to_bin_pipe: RTL and testbench

- Downstream stage for the binary-to-one-hot decoder.
- Accepts 16-bit one-hot vectors over a valid/ready handshake and encodes each to a 4-bit binary index.
- Flags illegal (zero-hot or multi-hot) inputs and buffers results in a 2-entry skid FIFO, so the decoder→encoder pair can run at full throughput under backpressure.
- Keeps a saturating count of illegal inputs for debug.

---
 rtl/onehot_to_bin_pipe.sv | 102 ++++++++++
 tb/tb_onehot_to_bin_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_to_bin_pipe.sv
// One-hot to binary encoder with illegal-input flagging, a 2-entry output FIFO
// and a saturating debug count of illegal inputs accepted.
module onehot_to_bin_pipe #(
    parameter int ONEHOT_W  = 16,
    parameter int BIN_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [ONEHOT_W-1:0]  onehot_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [BIN_W-1:0]     bin_o,
    output logic                 err_o,
    input  logic                 clr_cnt_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             state;
    logic [BIN_W-1:0] tail_bin;
    logic             tail_err;
    logic [BIN_W-1:0] enc_bin;
    logic             enc_err;
    logic             push;
    logic             pop;

    assign in_ready_o  = (state != TWO);
    assign out_valid_o = (state != EMPTY);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Scan from the top so the lowest set bit is the last to assign.
    always_comb begin
        enc_bin = '0;
        for (int unsigned i = ONEHOT_W; i > 0; i--) begin
            if (onehot_i[i-1]) begin
                enc_bin = BIN_W'(i - 1);
            end
        end
        enc_err = (onehot_i == '0) || ((onehot_i & (onehot_i - 1'b1)) != '0);
    end

    // The head entry lives directly in bin_o/err_o, so it holds when empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            bin_o    <= '0;
            err_o    <= 1'b0;
            tail_bin <= '0;
            tail_err <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        bin_o <= enc_bin;
                        err_o <= enc_err;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        bin_o <= enc_bin;
                        err_o <= enc_err;
                    end else if (push) begin
                        tail_bin <= enc_bin;
                        tail_err <= enc_err;
                        state    <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        bin_o <= tail_bin;
                        err_o <= tail_err;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            err_cnt_o <= '0;
        end else if (push && enc_err && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_to_bin_pipe.sv
// Self-checking bench for onehot_to_bin_pipe: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_onehot_to_bin_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] onehot_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  bin_o;
    logic        err_o;
    logic        clr_cnt_i;
    logic [7:0]  err_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: queue of {bin,err}, last shown head, error count.
    logic [4:0] q[$];
    logic [4:0] shown;
    int         m_cnt;

    onehot_to_bin_pipe #(.ONEHOT_W(16), .BIN_W(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .onehot_i(onehot_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .bin_o(bin_o), .err_o(err_o),
        .clr_cnt_i(clr_cnt_i), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    // Lowest set bit isolated arithmetically, then its log2 is the index.
    function automatic logic [4:0] model_enc(input logic [15:0] v);
        logic [15:0] low;
        logic [3:0]  b;
        low = v & (~v + 16'd1);
        b   = (v == 16'd0) ? 4'd0 : 4'($clog2(low));
        return {b, ($countones(v) != 1)};
    endfunction

    // Drive one cycle of inputs, advance one edge, update the model.
    task automatic cycle(input logic v, input logic [15:0] oh, input logic r, input logic c);
        logic push, pop;
        logic [4:0] e;
        in_valid_i = v; onehot_i = oh; out_ready_i = r; clr_cnt_i = c;
        push = v && (q.size() < 2);
        pop  = r && (q.size() > 0);
        e    = model_enc(oh);
        @(posedge clk);
        if (c) m_cnt = 0;
        else if (push && e[0] && m_cnt != 255) m_cnt++;
        if (pop) q.delete(0);
        if (push) q.push_back(e);
        if (q.size() > 0) shown = q[0];
        #1;
    endtask

    task automatic model_flush();
        q.delete();
        shown = 5'd0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
        n_cmp++; if ({bin_o, err_o} !== 5'd0) begin n_err++; $display("FAIL reset_head: got %h/%b want 0/0", bin_o, err_o); end
        n_cmp++; if (err_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", err_cnt_o); end
    endtask

    task automatic test_single();
        cycle(1'b1, 16'h0100, 1'b1, 1'b0);
        n_cmp++; if (out_valid_o !== 1'b1 || bin_o !== 4'h8 || err_o !== 1'b0) begin
            n_err++; $display("FAIL single_out: got v=%b bin=%h err=%b want v=1 bin=8 err=0", out_valid_o, bin_o, err_o); end
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL single_pop: got %b want 0", out_valid_o); end
        n_cmp++; if (bin_o !== 4'h8) begin n_err++; $display("FAIL single_hold: got %h want 8", bin_o); end
        n_cmp++; if (err_cnt_o !== 8'd0) begin n_err++; $display("FAIL single_cnt: got %0d want 0", err_cnt_o); end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 16'd1 << i, 1'b1, 1'b0);
            n_cmp++; if (out_valid_o !== 1'b1 || bin_o !== 4'(i) || err_o !== 1'b0) begin
                n_err++; $display("FAIL sweep_%0d: got v=%b bin=%h err=%b want v=1 bin=%h err=0", i, out_valid_o, bin_o, err_o, 4'(i)); end
            n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL sweep_ready_%0d: got %b want 1", i, in_ready_o); end
        end
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        cycle(1'b1, 16'h0000, 1'b1, 1'b0);
        n_cmp++; if ({bin_o, err_o} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL illegal_zero: got %h/%b want 0/1", bin_o, err_o); end
        cycle(1'b1, 16'h0A00, 1'b1, 1'b0);
        n_cmp++; if ({bin_o, err_o} !== {4'd9, 1'b1}) begin n_err++; $display("FAIL illegal_multi: got %h/%b want 9/1", bin_o, err_o); end
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        n_cmp++; if (err_cnt_o !== 8'd2) begin n_err++; $display("FAIL illegal_cnt: got %0d want 2", err_cnt_o); end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_seq[3];
        int got, guard;
        exp_seq[0] = {4'd0, 1'b0}; exp_seq[1] = {4'd15, 1'b0}; exp_seq[2] = {4'd4, 1'b0};
        cycle(1'b1, 16'h0001, 1'b0, 1'b0);
        cycle(1'b1, 16'h8000, 1'b0, 1'b0);
        n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_full: got ready=%b want 0", in_ready_o); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'h0010, 1'b0, 1'b0);
            n_cmp++; if ({bin_o, err_o} !== exp_seq[0] || in_ready_o !== 1'b0) begin
                n_err++; $display("FAIL bp_stall_%0d: got bin=%h ready=%b want bin=0 ready=0", i, bin_o, in_ready_o); end
        end
        // Release: the third vector stays presented until the model accepts it.
        got = 0; guard = 0;
        while (got < 3 && guard < 20) begin
            n_cmp++; if (out_valid_o !== 1'b1 || {bin_o, err_o} !== exp_seq[got]) begin
                n_err++; $display("FAIL bp_order_%0d: got v=%b bin=%h want v=1 bin=%h", got, out_valid_o, bin_o, exp_seq[got][4:1]); end
            cycle(q.size() < 2 && q.size() + got < 3 && !(q.size() == 1 && got == 2) ? 1'b1 : 1'b0,
                  16'h0010, 1'b1, 1'b0);
            got++; guard++;
        end
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drain: got v=%b want 0", out_valid_o); end
    endtask

    task automatic test_random();
        logic [15:0] oh;
        logic v, r, c;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       oh = 16'd0;
                1:       oh = 16'($urandom);
                default: oh = 16'd1 << $urandom_range(0, 15);
            endcase
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 31) == 0);
            cycle(v, oh, r, c);
            n_cmp++; if (out_valid_o !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_valid_o, q.size() > 0); end
            n_cmp++; if (in_ready_o !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", n, in_ready_o, q.size() < 2); end
            n_cmp++; if ({bin_o, err_o} !== shown) begin n_err++; $display("FAIL rnd_head@%0d: got %h/%b want %h/%b", n, bin_o, err_o, shown[4:1], shown[0]); end
            n_cmp++; if (err_cnt_o !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, err_cnt_o, m_cnt); end
        end
        while (q.size() > 0) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 256; i++) cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        n_cmp++; if (err_cnt_o !== 8'hFF || m_cnt != 255) begin n_err++; $display("FAIL sat_cnt: got %0d want 255", err_cnt_o); end
        cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        n_cmp++; if (err_cnt_o !== 8'hFF) begin n_err++; $display("FAIL sat_hold: got %0d want 255", err_cnt_o); end
        cycle(1'b1, 16'hFFFF, 1'b1, 1'b1);
        n_cmp++; if (err_cnt_o !== 8'd0) begin n_err++; $display("FAIL sat_clr: got %0d want 0", err_cnt_o); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_midreset();
        cycle(1'b1, 16'h0040, 1'b0, 1'b0);
        cycle(1'b1, 16'h0800, 1'b0, 1'b0);
        n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL mr_full: got ready=%b want 0", in_ready_o); end
        in_valid_i = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL mr_async: got v=%b ready=%b want v=0 ready=1", out_valid_o, in_ready_o); end
        model_flush();
        @(posedge clk);
        #1 reset_n = 1'b1;
        cycle(1'b1, 16'h0004, 1'b1, 1'b0);
        n_cmp++; if (out_valid_o !== 1'b1 || {bin_o, err_o} !== {4'd2, 1'b0}) begin
            n_err++; $display("FAIL mr_push: got v=%b bin=%h err=%b want v=1 bin=2 err=0", out_valid_o, bin_o, err_o); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL mr_stale: got v=%b want 0", out_valid_o); end
    endtask

    initial begin
        reset_n = 1'b0; in_valid_i = 1'b0; onehot_i = '0; out_ready_i = 1'b0; clr_cnt_i = 1'b0;
        model_flush();
        #12 reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_sweep();
        test_illegal();
        test_backpressure();
        test_random();
        test_saturate();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
